// File: rtl/led_scanner_pkg.sv
// Shared types and constants for the LED bar scanner.
package led_scanner_pkg;

    // Scanner FSM states.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StUp      = 3'd1,
        StDwellHi = 3'd2,
        StDown    = 3'd3,
        StDwellLo = 3'd4
    } state_e;

    // Direction encoding on the dir output.
    localparam logic DirUp   = 1'b0;
    localparam logic DirDown = 1'b1;

endpackage

// File: rtl/led_scanner_if.sv
// Scanner control/status bundle: step inputs from the prescaler side, LED drive and status out.
interface led_scanner_if #(
    parameter int unsigned N_LEDS = 8,
    parameter int unsigned PW     = $clog2(N_LEDS)
) ();
    logic              en;
    logic              p_e;
    logic [N_LEDS-1:0] leds;
    logic [PW-1:0]     pos;
    logic              dir;
    logic              bounce;

    // Upstream side: enables and steps the scanner, observes the bar.
    modport master (
        output en, p_e,
        input  leds, pos, dir, bounce
    );

    // Scanner side.
    modport slave (
        input  en, p_e,
        output leds, pos, dir, bounce
    );
endinterface

// File: rtl/led_scanner_end_dwell_counter.sv
// Tick-enabled counter shared by both end-dwell states; done flags the last dwell tick.
module led_scanner_end_dwell_counter #(
    parameter int unsigned DWELL = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic done_o
);
    localparam int unsigned CW = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] Last = CW'((DWELL > 0) ? DWELL - 1 : 0);

    logic [CW-1:0] cnt_q, cnt_d;

    // Clear wins over increment so a reversal always leaves the count at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (DWELL > 0) && (cnt_q == Last);
endmodule

// File: rtl/led_scanner.sv
// Knight-Rider LED bar scanner: a TAIL-wide lit window bounces between the ends of the bar,
// one step per enabled prescaler tick, optionally dwelling DWELL extra ticks at each end.
module led_scanner
    import led_scanner_pkg::*;
#(
    parameter int unsigned N_LEDS = 8,
    parameter int unsigned TAIL   = 1,
    parameter int unsigned DWELL  = 0
) (
    input  logic          clk,
    input  logic          rst,
    led_scanner_if.slave  bus
);
    localparam int unsigned       PW     = $clog2(N_LEDS);
    localparam int unsigned       MAXP   = N_LEDS - TAIL;
    localparam logic [PW-1:0]     MaxPos = PW'(MAXP);
    localparam logic [N_LEDS-1:0] Window = ~({N_LEDS{1'b1}} << TAIL);

    if (N_LEDS < 2 || TAIL < 1 || TAIL >= N_LEDS) begin : g_bad_params
        $error("led_scanner: need N_LEDS >= 2 and 1 <= TAIL < N_LEDS");
    end

    state_e            state_q, state_d;
    logic [PW-1:0]     pos_q, pos_d;
    logic              dir_q, dir_d;
    logic              bounce_q, bounce_d;
    logic [N_LEDS-1:0] leds_q, leds_d;
    logic              tick;
    logic              cnt_clr, cnt_inc, cnt_done;

    assign tick = bus.en & bus.p_e;

    led_scanner_end_dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .done_o (cnt_done)
    );

    // State and output registers; leds, pos and dir always move on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            pos_q    <= '0;
            dir_q    <= DirUp;
            bounce_q <= 1'b0;
            leds_q   <= '0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            bounce_q <= bounce_d;
            leds_q   <= leds_d;
        end
    end

    // Next state, position and direction; without a tick everything holds (freeze when en=0).
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Leaving idle needs only en, not a tick.
                if (bus.en) begin
                    state_d = StUp;
                    pos_d   = '0;
                    dir_d   = DirUp;
                    cnt_clr = 1'b1;
                end
            end
            StUp: begin
                if (tick) begin
                    if (pos_q != MaxPos) begin
                        pos_d = pos_q + 1'b1;
                    end else if (DWELL > 0) begin
                        state_d = StDwellHi;
                        cnt_clr = 1'b1;
                    end else begin
                        state_d = StDown;
                        dir_d   = DirDown;
                        pos_d   = MaxPos - 1'b1;
                    end
                end
            end
            StDwellHi: begin
                if (tick) begin
                    if (cnt_done) begin
                        state_d = StDown;
                        dir_d   = DirDown;
                        pos_d   = MaxPos - 1'b1;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            StDown: begin
                if (tick) begin
                    if (pos_q != '0) begin
                        pos_d = pos_q - 1'b1;
                    end else if (DWELL > 0) begin
                        state_d = StDwellLo;
                        cnt_clr = 1'b1;
                    end else begin
                        state_d = StUp;
                        dir_d   = DirUp;
                        pos_d   = PW'(1);
                    end
                end
            end
            StDwellLo: begin
                if (tick) begin
                    if (cnt_done) begin
                        state_d = StUp;
                        dir_d   = DirUp;
                        pos_d   = PW'(1);
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                pos_d   = '0;
                dir_d   = DirUp;
            end
        endcase
    end

    // Next LED drive and bounce pulse; bounce fires only when a tick moves pos onto an end.
    always_comb begin
        bounce_d = (state_q != StIdle) && (pos_d != pos_q) &&
                   ((pos_d == '0) || (pos_d == MaxPos));
        leds_d   = (state_d == StIdle) ? '0 : (Window << pos_d);
    end

    assign bus.leds   = leds_q;
    assign bus.pos    = pos_q;
    assign bus.dir    = dir_q;
    assign bus.bounce = bounce_q;
endmodule

// File: tb/tb_led_scanner.sv
// Directed bench: three scanner configurations stepped in lockstep by a 5-clock tick.
module tb_led_scanner;
    logic clk = 1'b0;
    logic rst;
    logic en;
    logic p_e;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_scanner_if #(.N_LEDS(8)) bus_a ();
    led_scanner_if #(.N_LEDS(8)) bus_b ();
    led_scanner_if #(.N_LEDS(8)) bus_c ();

    assign bus_a.en  = en;
    assign bus_a.p_e = p_e;
    assign bus_b.en  = en;
    assign bus_b.p_e = p_e;
    assign bus_c.en  = en;
    assign bus_c.p_e = p_e;

    led_scanner #(.N_LEDS(8), .TAIL(1), .DWELL(0)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
    led_scanner #(.N_LEDS(8), .TAIL(1), .DWELL(2)) u_b (.clk(clk), .rst(rst), .bus(bus_b));
    led_scanner #(.N_LEDS(8), .TAIL(3), .DWELL(0)) u_c (.clk(clk), .rst(rst), .bus(bus_c));

    // Expected state after tick k (index k-1).
    logic [7:0] leds_a [24] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04,
                                8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20, 8'h10};
    logic [2:0] pos_a  [24] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2,
                                3, 4, 5, 6, 7, 6, 5, 4};
    logic       dir_a  [24] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0,
                                0, 0, 0, 0, 0, 1, 1, 1};
    logic       bnc_a  [24] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0,
                                0, 0, 0, 0, 1, 0, 0, 0};

    logic [7:0] leds_b [24] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h80,
                                8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                                8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
    logic [2:0] pos_b  [24] = '{1, 2, 3, 4, 5, 6, 7, 7, 7, 6, 5, 4, 3, 2, 1, 0,
                                0, 0, 1, 2, 3, 4, 5, 6};
    logic       dir_b  [24] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1,
                                1, 1, 0, 0, 0, 0, 0, 0};
    logic       bnc_b  [24] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                                0, 0, 0, 0, 0, 0, 0, 0};

    logic [7:0] leds_c [24] = '{8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'h70, 8'h38, 8'h1C,
                                8'h0E, 8'h07, 8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'h70,
                                8'h38, 8'h1C, 8'h0E, 8'h07, 8'h0E, 8'h1C, 8'h38, 8'h70};
    logic [2:0] pos_c  [24] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5, 4,
                                3, 2, 1, 0, 1, 2, 3, 4};
    logic       dir_c  [24] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1,
                                1, 1, 1, 1, 0, 0, 0, 0};
    logic       bnc_c  [24] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0,
                                0, 0, 0, 1, 0, 0, 0, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Snapshot {leds, pos, dir, bounce} of DUT w (0 = A, 1 = B, 2 = C).
    function automatic logic [12:0] obs(input int w);
        case (w)
            0:       return {bus_a.leds, bus_a.pos, bus_a.dir, bus_a.bounce};
            1:       return {bus_b.leds, bus_b.pos, bus_b.dir, bus_b.bounce};
            default: return {bus_c.leds, bus_c.pos, bus_c.dir, bus_c.bounce};
        endcase
    endfunction

    task automatic check_scan(input string tag, input int w, input logic [7:0] l,
                              input logic [2:0] p, input logic d, input logic b);
        logic [12:0] o;
        o = obs(w);
        check({tag, " leds"},   32'(o[12:5]), 32'(l));
        check({tag, " pos"},    32'(o[4:2]),  32'(p));
        check({tag, " dir"},    32'(o[1]),    32'(d));
        check({tag, " bounce"}, 32'(o[0]),    32'(b));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        p_e = 1'b0;

        // Reset held two clocks with a coincident p_e: nothing may move.
        @(negedge clk);
        p_e = 1'b1;
        @(negedge clk);
        check_scan("rst A", 0, 8'h00, 3'd0, 1'b0, 1'b0);
        check_scan("rst B", 1, 8'h00, 3'd0, 1'b0, 1'b0);
        check_scan("rst C", 2, 8'h00, 3'd0, 1'b0, 1'b0);

        // Leaving reset with en=1: first clock enters UP at position 0 without a tick.
        rst = 1'b0;
        p_e = 1'b0;
        @(negedge clk);
        check_scan("start A", 0, 8'h01, 3'd0, 1'b0, 1'b0);
        check_scan("start C", 2, 8'h07, 3'd0, 1'b0, 1'b0);

        for (int k = 1; k <= 24; k++) begin
            p_e = 1'b1;
            @(negedge clk);
            p_e = 1'b0;
            check_scan($sformatf("A k%0d", k), 0, leds_a[k-1], pos_a[k-1], dir_a[k-1],
                       bnc_a[k-1]);
            check_scan($sformatf("B k%0d", k), 1, leds_b[k-1], pos_b[k-1], dir_b[k-1],
                       bnc_b[k-1]);
            check_scan($sformatf("C k%0d", k), 2, leds_c[k-1], pos_c[k-1], dir_c[k-1],
                       bnc_c[k-1]);
            repeat (4) @(negedge clk);
            check($sformatf("A hold leds k%0d", k), 32'(bus_a.leds), 32'(leds_a[k-1]));
            check($sformatf("C hold bounce k%0d", k), 32'(bus_c.bounce), 32'd0);

            // Freeze for 60 clocks at leds=08 moving up while p_e keeps pulsing.
            if (k == 3) begin
                en = 1'b0;
                for (int i = 0; i < 60; i++) begin
                    p_e = (i % 5 == 0);
                    @(negedge clk);
                end
                p_e = 1'b0;
                check_scan("frz A", 0, 8'h08, 3'd3, 1'b0, 1'b0);
                check_scan("frz B", 1, 8'h08, 3'd3, 1'b0, 1'b0);
                check_scan("frz C", 2, 8'h38, 3'd3, 1'b0, 1'b0);
                en = 1'b1;
            end
        end

        // Mid-scan reset (A at 10 moving down) coincident with a tick.
        rst = 1'b1;
        p_e = 1'b1;
        @(negedge clk);
        check_scan("midrst A", 0, 8'h00, 3'd0, 1'b0, 1'b0);
        check_scan("midrst B", 1, 8'h00, 3'd0, 1'b0, 1'b0);

        // Idle with en low stays dark.
        rst = 1'b0;
        p_e = 1'b0;
        en  = 1'b0;
        repeat (2) @(negedge clk);
        check_scan("idle A", 0, 8'h00, 3'd0, 1'b0, 1'b0);

        en = 1'b1;
        @(negedge clk);
        check_scan("restart A", 0, 8'h01, 3'd0, 1'b0, 1'b0);
        check_scan("restart C", 2, 8'h07, 3'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
